uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// UART_TX_PARITY_EN adds the even-parity state to the encoding.
package uart_pkg;
  localparam int DATA_W          = 8;
  localparam int FRAME_BITS_BASE = 10;
  localparam int FRAME_BITS_PAR  = 11;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  localparam int FRAME_BITS = FRAME_BITS_BASE;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIVISION-1 and flags the last clock of each bit.
// A synchronous restart parks the count at 0 so a new bit starts on a clean boundary.
module uart_baud_gen #(
  parameter int DIVISION = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(DIVISION - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SYS_CLOCK = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              busy
);
  localparam int DIVISION = SYS_CLOCK / BAUD_RATE;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              tx_serial_q, tx_serial_d;
  logic              busy_q, busy_d;
  logic              tick, accept;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Counter is held at 0 while idle so the start bit gets a full period.
  uart_baud_gen #(.DIVISION(DIVISION)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  assign tx_ready  = (state_q == IDLE) && !reset;
  assign accept    = tx_valid && tx_ready;
  assign tx_serial = tx_serial_q;
  assign busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_serial_d = tx_serial_q;
    busy_d      = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_serial_d = 1'b1;
        if (accept) begin
          state_d     = START;
          shift_d     = tx_data;
          bit_idx_d   = '0;
          tx_serial_d = 1'b0;
          busy_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^tx_data;
`endif
        end
      end
      START: if (tick) begin
        state_d     = DATA;
        tx_serial_d = shift_q[0];
        shift_d     = {1'b0, shift_q[DATA_W-1:1]};
      end
      DATA: if (tick) begin
        if (bit_idx_q == 3'd7) begin
          bit_idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          state_d     = PARITY;
          tx_serial_d = parity_q;
`else
          state_d     = STOP;
          tx_serial_d = 1'b1;
`endif
        end else begin
          bit_idx_d   = bit_idx_q + 3'd1;
          tx_serial_d = shift_q[0];
          shift_d     = {1'b0, shift_q[DATA_W-1:1]};
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_d     = STOP;
        tx_serial_d = 1'b1;
      end
`endif
      STOP: if (tick) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        tx_serial_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_serial_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_serial_q <= tx_serial_d;
      busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a monitor
// decodes each frame cycle by cycle at the falling clock edge.
module tb_uart_tx;
  localparam int DIV = 104;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_serial, busy;

  exp_t exp_q[$];
  bit   mon_active = 1'b0;
  int   total = 0;
  int   bad = 0;

  uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(logic [7:0] d, logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) until the line is idle and the monitor has finished.
  task automatic wait_frames(output int busy_cyc);
    int n;
    busy_cyc = 0;
    n = 0;
    while ((busy || mon_active) && n < 3000) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) check("wait_timeout", 1, 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: a low line outside reset marks a start bit.
  initial begin : monitor
    exp_t         e;
    logic [NB-1:0] fr;
    int           mism;
    bit           ab;
    forever begin
      @(negedge clk);
      if (!reset && tx_serial === 1'b0) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          e.data = 8'h00;
          e.par  = 1'b0;
        end else begin
          e = exp_q.pop_front();
        end
        fr[0]   = 1'b0;
        fr[8:1] = e.data;
`ifdef UART_TX_PARITY_EN
        fr[9]   = e.par;
        fr[10]  = 1'b1;
`else
        fr[9]   = 1'b1;
`endif
        ab = 1'b0;
        for (int b = 0; b < NB && !ab; b++) begin
          mism = 0;
          for (int c = 0; c < DIV; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (reset) begin
              ab = 1'b1;
              break;
            end
            if (tx_serial !== fr[b] || busy !== 1'b1 || tx_ready !== 1'b0) mism++;
          end
          if (!ab) check($sformatf("frame_%02h_bit%0d_bad_cycles", e.data, b), mism, 0);
        end
        if (!ab) begin
          @(negedge clk);
          check($sformatf("frame_%02h_post_idle", e.data),
                {29'd0, tx_serial, busy, tx_ready}, 32'b101);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : stim
    int bc;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", tx_ready, 0);
    check("rst_serial", tx_serial, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", tx_ready, 1);

    // Single 0x55 pulse: latency 1, alternating line, busy for 10 bit periods
    tx_data = 8'h55; tx_valid = 1'b1; push(8'h55, 1'b0);
    check("pre_accept_serial", tx_serial, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("lat1_serial", tx_serial, 0);
    check("lat1_busy", busy, 1);
    check("lat1_ready", tx_ready, 0);
    wait_frames(bc);
    check("busy_cycles_55", bc, NB * DIV);

    // Back-to-back 0xA5 then 0x3C with valid held
    tx_data = 8'hA5; tx_valid = 1'b1; push(8'hA5, 1'b0); push(8'h3C, 1'b0);
    @(posedge clk); #1;
    tx_data = 8'h3C;
    n = 0;
    while (!tx_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check("b2b_ready_seen", tx_ready, 1);
    check("b2b_gap_serial", tx_serial, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("b2b_ready_one_cycle", tx_ready, 0);
    check("b2b_second_start", tx_serial, 0);
    wait_frames(bc);

    // 0x00 with tx_data/tx_valid disturbed mid-frame
    tx_data = 8'h00; tx_valid = 1'b1; push(8'h00, 1'b0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (200) begin @(posedge clk); #1; end
    tx_data = 8'hFF; tx_valid = 1'b1;
    repeat (300) begin @(posedge clk); #1; end
    tx_valid = 1'b0;
    wait_frames(bc);

    // Reset at clock 500 of a 0xC3 frame
    tx_data = 8'hC3; tx_valid = 1'b1; push(8'hC3, 1'b0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (499) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_serial", tx_serial, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_release_ready", tx_ready, 1);
    check("abort_q_drained", exp_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_line_idle", tx_serial, 1);

    // Clean frame after abort
    tx_data = 8'h3C; tx_valid = 1'b1; push(8'h3C, 1'b0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("post_abort_start", tx_serial, 0);
    wait_frames(bc);
    check("busy_cycles_3c", bc, NB * DIV);

    // 0x07: odd number of ones, parity bit 1 when enabled
    tx_data = 8'h07; tx_valid = 1'b1; push(8'h07, 1'b1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_frames(bc);
    check("busy_cycles_07", bc, NB * DIV);

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
